// File: rtl/secant_sequencer.sv
// secant_sequencer: drives one secant-solver current search.
// Each evaluation applies a candidate, settles, averages ADC samples, then checks convergence.
module secant_sequencer #(
    parameter int WIDTH    = 10,
    parameter int TOL      = 30,
    parameter int SETTLE   = 16,
    parameter int AVG_LOG2 = 2,
    parameter int MAX_ITER = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [WIDTH-1:0]                desired_q,
    input  logic                            adc_valid,
    input  logic [WIDTH-1:0]                adc_data,
    input  logic [WIDTH-1:0]                cand_i,
    input  logic                            cand_valid,
    output logic                            step,
    output logic [WIDTH-1:0]                q_avg,
    output logic [WIDTH-1:0]                i_ref,
    output logic                            busy,
    output logic                            done,
    output logic                            converged,
    output logic                            timeout,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int CW = AVG_LOG2 + 1;
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int IW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_CHECK, S_STEP, S_WAIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  tgt_q, tgt_d, i_ref_q, i_ref_d, q_avg_q, q_avg_d;
    logic [AW-1:0]     acc_q, acc_d, sum;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic              conv_q, conv_d, tmo_q, tmo_d;
    logic signed [WIDTH:0] diff;
    logic [WIDTH:0]    err;
    logic              hit, last;

    assign sum  = acc_q + AW'(adc_data);
    // WIDTH+1-bit signed difference of two unsigned values cannot overflow
    assign diff = $signed({1'b0, q_avg_q}) - $signed({1'b0, tgt_q});
    assign err  = diff < 0 ? -diff : diff;
    assign hit  = err < (WIDTH + 1)'(TOL);
    assign last = iter_q == IW'(MAX_ITER - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            i_ref_q  <= '0;
            q_avg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            i_ref_q  <= i_ref_d;
            q_avg_q  <= q_avg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            iter_q   <= iter_d;
            conv_q   <= conv_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        i_ref_d  = i_ref_q;
        q_avg_d  = q_avg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        iter_d   = iter_q;
        conv_d   = conv_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE: if (start) begin
                tgt_d   = desired_q;
                iter_d  = '0;
                conv_d  = 1'b0;
                tmo_d   = 1'b0;
                state_d = S_APPLY;
            end
            S_APPLY: begin
                i_ref_d  = cand_i;
                settle_d = SW'(SETTLE - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: if (settle_q == '0) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_SAMPLE;
            end else begin
                settle_d = settle_q - SW'(1);
            end
            S_SAMPLE: if (adc_valid) begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'((1 << AVG_LOG2) - 1)) begin
                    q_avg_d = WIDTH'(sum >> AVG_LOG2);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: if (hit) begin
                conv_d  = 1'b1;
                state_d = S_DONE;
            end else if (last) begin
                tmo_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                state_d = S_STEP;
            end
            S_STEP: begin
                iter_d  = iter_q + IW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: state_d = cand_valid ? S_APPLY : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != S_IDLE;
        done      = state_q == S_DONE;
        step      = state_q == S_STEP;
        q_avg     = q_avg_q;
        i_ref     = i_ref_q;
        converged = conv_q;
        timeout   = tmo_q;
        iter      = iter_q;
    end
endmodule

// File: tb/tb_secant_sequencer.sv
// tb_secant_sequencer: directed vector table plus hand-written multi-cycle sequences.
module tb_secant_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, adc_valid = 1'b1, cand_valid = 1'b0;
    logic [9:0] desired_q = '0, adc_data = '0, cand_i = '0, adc_const = '0;
    logic       step, busy, done, converged, timeout;
    logic [9:0] q_avg, i_ref;
    logic [3:0] iter;
    int         n_vec = 0, n_bad = 0, cyc = 0, mode = 0, cidx = 0, steps = 0;
    bit         step_d = 1'b0;
    logic [9:0] cands[3] = '{10'd0, 10'd1022, 10'd645};

    typedef struct {
        logic [9:0] dq, cand, adc, q;
        bit         conv, tmo;
        int         it, dcyc;
    } vec_t;
    vec_t vt[9];

    secant_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .desired_q(desired_q),
        .adc_valid(adc_valid), .adc_data(adc_data), .cand_i(cand_i),
        .cand_valid(cand_valid), .step(step), .q_avg(q_avg), .i_ref(i_ref),
        .busy(busy), .done(done), .converged(converged), .timeout(timeout),
        .iter(iter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the middle of the next cycle; the solver answers one cycle after each step.
    task automatic tick();
        @(negedge clk);
        cyc++;
        start = 1'b0;
        cand_valid = step_d;
        if (step_d && mode == 1 && cidx < 2) begin
            cidx++;
            cand_i = cands[cidx];
        end
        step_d = step;
        if (step) steps++;
        if (mode == 0) adc_data = adc_const;
        else if (mode == 1) adc_data = 10'(2 * int'(cand_i) / 5);
    endtask

    task automatic launch(input logic [9:0] dq, output int n);
        tick();
        start = 1'b1;
        desired_q = dq;
        n = cyc;
        steps = 0;
        step_d = 1'b0;
    endtask

    task automatic finish_run(input int n, output int dc);
        dc = -1;
        for (int k = 0; k < 400 && dc < 0; k++) begin
            tick();
            if (done === 1'b1) dc = cyc - n;
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " i_ref"}, i_ref, 0);
        chk({nm, " q_avg"}, q_avg, 0);
        chk({nm, " step"}, step, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " converged"}, converged, 0);
        chk({nm, " timeout"}, timeout, 0);
        chk({nm, " iter"}, iter, 0);
    endtask

    initial begin
        int n, dc, dn;
        vt[0] = '{10'd258,  10'd250,  10'd260,  10'd260,  1'b1, 1'b0, 0, 23};
        vt[1] = '{10'd258,  10'd250,  10'd288,  10'd288,  1'b0, 1'b1, 7, 191};
        vt[2] = '{10'd258,  10'd250,  10'd287,  10'd287,  1'b1, 1'b0, 0, 23};
        vt[3] = '{10'd500,  10'd250,  10'd100,  10'd100,  1'b0, 1'b1, 7, 191};
        vt[4] = '{10'd0,    10'd5,    10'd29,   10'd29,   1'b1, 1'b0, 0, 23};
        vt[5] = '{10'd0,    10'd5,    10'd30,   10'd30,   1'b0, 1'b1, 7, 191};
        vt[6] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b1, 1'b0, 0, 23};
        vt[7] = '{10'd1023, 10'd7,    10'd0,    10'd0,    1'b0, 1'b1, 7, 191};
        vt[8] = '{10'd0,    10'd7,    10'd1023, 10'd1023, 1'b0, 1'b1, 7, 191};

        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        foreach (vt[i]) begin
            mode = 0;
            adc_const = vt[i].adc;
            cand_i = vt[i].cand;
            adc_valid = 1'b1;
            launch(vt[i].dq, n);
            finish_run(n, dc);
            chk($sformatf("v%0d done_cycle", i), dc, vt[i].dcyc);
            chk($sformatf("v%0d q_avg", i), q_avg, vt[i].q);
            chk($sformatf("v%0d converged", i), converged, vt[i].conv);
            chk($sformatf("v%0d timeout", i), timeout, vt[i].tmo);
            chk($sformatf("v%0d iter", i), iter, vt[i].it);
            chk($sformatf("v%0d i_ref", i), i_ref, vt[i].cand);
            chk($sformatf("v%0d steps", i), steps, vt[i].it);
            tick();
            chk($sformatf("v%0d busy_after", i), busy, 0);
        end

        // cycle-accurate first-try convergence with ignored start and cand_valid while busy
        mode = 0;
        adc_const = 10'd260;
        cand_i = 10'd250;
        launch(10'd258, n);
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) chk("seqA busy_n1", busy, 1);
            if (k == 2) chk("seqA i_ref_n2", i_ref, 250);
            if (k == 5) begin start = 1'b1; desired_q = 10'd0; end
            if (k == 8) begin cand_valid = 1'b1; cand_i = 10'd999; end
            if (k == 9) cand_i = 10'd250;
            if (k == 22) begin chk("seqA q_avg_n22", q_avg, 260); chk("seqA done_n22", done, 0); end
            if (k == 23) begin
                chk("seqA done_n23", done, 1);
                chk("seqA converged", converged, 1);
                chk("seqA timeout", timeout, 0);
                chk("seqA iter", iter, 0);
                chk("seqA i_ref", i_ref, 250);
            end
            if (k == 24) chk("seqA busy_n24", busy, 0);
        end

        // plant q = 2*i/5 with solver candidates 0, 1022, 645
        mode = 1;
        cidx = 0;
        cand_i = cands[0];
        launch(10'd258, n);
        finish_run(n, dc);
        chk("seqB done_cycle", dc, 71);
        chk("seqB converged", converged, 1);
        chk("seqB timeout", timeout, 0);
        chk("seqB iter", iter, 2);
        chk("seqB i_ref", i_ref, 645);
        chk("seqB q_avg", q_avg, 258);
        chk("seqB steps", steps, 2);

        // averaging with 3-cycle adc_valid gaps and garbage outside valid samples
        mode = 2;
        cand_i = 10'd100;
        launch(10'd101, n);
        dc = -1;
        for (int k = 1; k <= 60 && dc < 0; k++) begin
            tick();
            if (k >= 18 && k <= 30 && (k - 18) % 4 == 0) begin
                adc_valid = 1'b1;
                adc_data = 10'(100 + (k - 18) / 4);
            end else begin
                adc_valid = k < 18;
                adc_data = 10'd900;
            end
            if (done === 1'b1) dc = cyc - n;
        end
        chk("seqC done_cycle", dc, 32);
        chk("seqC q_avg", q_avg, 101);
        chk("seqC converged", converged, 1);

        // reset while stalled in SAMPLE, then a clean search
        mode = 0;
        adc_const = 10'd260;
        cand_i = 10'd250;
        adc_valid = 1'b0;
        launch(10'd258, n);
        for (int k = 1; k <= 20; k++) tick();
        chk("seqD busy_stalled", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("seqD");
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        chk("seqD no_done_idle", dn, 0);
        adc_valid = 1'b1;
        launch(10'd258, n);
        finish_run(n, dc);
        chk("seqD done_cycle", dc, 23);
        chk("seqD converged", converged, 1);
        chk("seqD iter", iter, 0);
        chk("seqD i_ref", i_ref, 250);
        chk("seqD q_avg", q_avg, 260);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
